gen1_skp_insert: RTL and testbench

- Gen1/Gen2 TX ordered-set inserter sitting directly upstream of gen1_scramble.
- Accepts the link-layer byte stream (up to 4 bytes/beat, K flags per byte) with a valid/ready handshake.
- Every SKP_INTERVAL symbol times, stalls upstream at a packet boundary and injects a SKP ordered set (COM SKP SKP SKP).
- Its output feeds the scrambler's data/K/valid inputs directly; that stage consumes one beat every cycle.

---
 rtl/pcie_phy_pkg.sv | 53 +++++
 rtl/gen1_skp_insert.sv | 108 ++++++++++
 tb/tb_gen1_skp_insert.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY symbol constants, ordered-set sizes and the SKP inserter state type.
package pcie_phy_pkg;

    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] SKP        = 8'h1C;
    localparam int         SKP_OS_LEN = 4;

    typedef enum logic {
        PASS = 1'b0,
        EMIT = 1'b1
    } skp_state_e;

    // Legal PIPE widths are 8/16/32; anything else runs as a 32-bit lane.
    function automatic logic [2:0] bytes_per_beat(input logic [5:0] pipe_width);
        logic [2:0] bpb;
        case (pipe_width)
            6'd8:    bpb = 3'd1;
            6'd16:   bpb = 3'd2;
            default: bpb = 3'd4;
        endcase
        return bpb;
    endfunction

    function automatic logic [31:0] skp_beat_data(input logic [2:0] bpb, input logic [1:0] idx);
        logic [31:0] d;
        int          pos;
        d = 32'h0000_0000;
        for (int j = 0; j < 4; j++) begin
            pos = int'(idx) * int'(bpb) + j;
            if (j < int'(bpb)) begin
                d[j*8 +: 8] = (pos == 0) ? COM : SKP;
            end else begin
                d[j*8 +: 8] = 8'h00;
            end
        end
        return d;
    endfunction

    function automatic logic [3:0] skp_beat_k(input logic [2:0] bpb);
        logic [3:0] k;
        case (bpb)
            3'd1:    k = 4'h1;
            3'd2:    k = 4'h3;
            default: k = 4'hF;
        endcase
        return k;
    endfunction

    function automatic logic is_last_skp_beat(input logic [2:0] bpb, input logic [1:0] idx);
        return ((5'(idx) + 5'd1) * 5'(bpb)) == 5'(SKP_OS_LEN);
    endfunction

endpackage

// File: rtl/gen1_skp_insert.sv
// Gen1/Gen2 TX SKP ordered-set inserter: schedules SKP OS every SKP_INTERVAL symbols
// and splices them into the link-layer stream at packet boundaries.
module gen1_skp_insert
    import pcie_phy_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int MAX_PENDING  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  pipe_width_i,
    input  logic [31:0] data_in_i,
    input  logic [3:0]  data_k_in_i,
    input  logic        data_valid_i,
    input  logic        boundary_i,
    output logic        data_ready_o,
    input  logic        force_skp_i,
    output logic [31:0] data_out_o,
    output logic [3:0]  data_k_out_o,
    output logic        data_valid_o,
    output logic        skp_sent_o
);

    localparam int CNT_W  = $clog2(SKP_INTERVAL + 4);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        skp_state_e          state;
        logic [1:0]          idx;
        logic [CNT_W-1:0]    count;
        logic [PEND_W-1:0]   pending;
        logic [31:0]         data;
        logic [3:0]          k;
        logic                valid;
        logic                skp_sent;
    } regs_t;

    regs_t              q_r;
    regs_t              d_s;
    logic [2:0]         bpb_s;
    logic [CNT_W-1:0]   sum_s;
    logic               expire_s;
    logic               insert_s;
    logic [1:0]         beat_idx_s;
    logic               last_s;
    logic [PEND_W+1:0]  pend_sum_s;

    assign bpb_s      = bytes_per_beat(pipe_width_i);
    assign sum_s      = q_r.count + CNT_W'(bpb_s);
    assign expire_s   = (sum_s >= CNT_W'(SKP_INTERVAL));
    assign insert_s   = (q_r.state == PASS) && (q_r.pending != '0) && (!data_valid_i || boundary_i);
    assign beat_idx_s = (q_r.state == EMIT) ? q_r.idx : 2'd0;
    assign last_s     = is_last_skp_beat(bpb_s, beat_idx_s);

    // An insertion start consumes one request while expiry/force may add up to two in the same cycle.
    assign pend_sum_s = (PEND_W+2)'(q_r.pending) + (PEND_W+2)'(expire_s)
                      + (PEND_W+2)'(force_skp_i) - (PEND_W+2)'(insert_s);

    assign data_ready_o = (q_r.state == PASS) && !insert_s;

    // Next-state computation for the whole D/Q register.
    always_comb begin
        d_s          = q_r;
        d_s.skp_sent = 1'b0;
        d_s.count    = expire_s ? (sum_s - CNT_W'(SKP_INTERVAL)) : sum_s;

        if (pend_sum_s > (PEND_W+2)'(MAX_PENDING)) begin
            d_s.pending = PEND_W'(MAX_PENDING);
        end else begin
            d_s.pending = pend_sum_s[PEND_W-1:0];
        end

        if ((q_r.state == EMIT) || insert_s) begin
            d_s.data  = skp_beat_data(bpb_s, beat_idx_s);
            d_s.k     = skp_beat_k(bpb_s);
            d_s.valid = 1'b1;
            if (last_s) begin
                d_s.skp_sent = 1'b1;
                d_s.state    = PASS;
                d_s.idx      = 2'd0;
            end else begin
                d_s.state    = EMIT;
                d_s.idx      = beat_idx_s + 2'd1;
            end
        end else begin
            d_s.state = PASS;
            d_s.idx   = 2'd0;
            d_s.valid = data_valid_i;
            d_s.data  = data_valid_i ? data_in_i : 32'h0000_0000;
            d_s.k     = data_valid_i ? data_k_in_i : 4'h0;
        end
    end

    // State and output register; reset aborts any ordered set in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_r <= '0;
        end else begin
            q_r <= d_s;
        end
    end

    assign data_out_o   = q_r.data;
    assign data_k_out_o = q_r.k;
    assign data_valid_o = q_r.valid;
    assign skp_sent_o   = q_r.skp_sent;

endmodule

// File: tb/tb_gen1_skp_insert.sv
// Directed scoreboard bench for gen1_skp_insert: every cycle's expected output is queued
// when stimulus is applied and compared one edge later.
module tb_gen1_skp_insert;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [5:0]  pipe_width_i = 6'd32;
    logic [31:0] data_in_i = 32'h0;
    logic [3:0]  data_k_in_i = 4'h0;
    logic        data_valid_i = 1'b0;
    logic        boundary_i = 1'b0;
    logic        force_skp_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] data_out_o;
    logic [3:0]  data_k_out_o;
    logic        data_valid_o;
    logic        skp_sent_o;

    gen1_skp_insert dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pipe_width_i (pipe_width_i),
        .data_in_i    (data_in_i),
        .data_k_in_i  (data_k_in_i),
        .data_valid_i (data_valid_i),
        .boundary_i   (boundary_i),
        .data_ready_o (data_ready_o),
        .force_skp_i  (force_skp_i),
        .data_out_o   (data_out_o),
        .data_k_out_o (data_k_out_o),
        .data_valid_o (data_valid_o),
        .skp_sent_o   (skp_sent_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic        s;
    } beat_t;

    beat_t exp_q[$];
    beat_t skp_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic beat_t skp_beat(input int b, input int i);
        beat_t e;
        e.v = 1'b1;
        if (b == 4) begin
            e.d = 32'h1C1C_1CBC; e.k = 4'hF; e.s = 1'b1;
        end else if (b == 2) begin
            e.d = (i == 0) ? 32'h0000_1CBC : 32'h0000_1C1C;
            e.k = 4'h3; e.s = (i == 1);
        end else begin
            e.d = (i == 0) ? 32'h0000_00BC : 32'h0000_001C;
            e.k = 4'h1; e.s = (i == 3);
        end
        return e;
    endfunction

    task automatic push_skp(input int b);
        for (int i = 0; i < 4 / b; i++) skp_q.push_back(skp_beat(b, i));
    endtask

    // One clock: check ready, queue the expected output, then compare it after the edge.
    task automatic tick();
        beat_t e;
        #1;
        chk("ready", data_ready_o, (skp_q.size() == 0));
        acc = data_valid_i && data_ready_o;
        if (skp_q.size() != 0) e = skp_q.pop_front();
        else if (acc)         e = '{1'b1, data_in_i, data_k_in_i, 1'b0};
        else                  e = '{1'b0, 32'h0, 4'h0, 1'b0};
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        chk("valid_out", data_valid_o, e.v);
        chk("data_out", data_out_o, e.d);
        chk("k_out", data_k_out_o, e.k);
        chk("skp_sent", skp_sent_o, e.s);
    endtask

    task automatic do_reset(input logic [5:0] w);
        rst_ni = 1'b0;
        data_valid_i = 1'b0; boundary_i = 1'b0; force_skp_i = 1'b0;
        data_in_i = 32'h0; data_k_in_i = 4'h0; pipe_width_i = w;
        skp_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_valid", data_valid_o, 1'b0);
        chk("reset_data", data_out_o, 32'h0);
        chk("reset_k", data_k_out_o, 4'h0);
        chk("reset_skp", skp_sent_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic stream_then_boundary(input int nbeats, input int b, input int nos);
        logic fresh;
        int   tries;
        fresh = 1'b1;
        for (int n = 1; n <= nbeats; n++) begin
            if (fresh) begin
                data_valid_i = 1'b1; boundary_i = 1'b0;
                data_in_i = $urandom; data_k_in_i = 4'($urandom);
            end
            tick();
            fresh = acc;
        end
        data_valid_i = 1'b1; boundary_i = 1'b1;
        data_in_i = $urandom; data_k_in_i = 4'($urandom);
        for (int i = 0; i < nos; i++) push_skp(b);
        tries = 0;
        do begin
            tick();
            tries++;
        end while (!acc && tries < 8);
        chk("held_beat_accepted", acc, 1'b1);
        data_valid_i = 1'b0; boundary_i = 1'b0;
        tick();
        chk("skp_plan_drained", skp_q.size(), 0);
    endtask

    initial begin
        #1;
        // Width 32, idle input with garbage data: SKP every 295 beats.
        do_reset(6'd32);
        for (int n = 1; n <= 900; n++) begin
            data_in_i = $urandom;
            if (n > 1 && (n - 1) % 295 == 0) push_skp(4);
            tick();
        end
        data_in_i = 32'h0;

        // Width 16: SKP held off until a boundary beat, which is then replayed.
        do_reset(6'd16);
        stream_then_boundary(700, 2, 1);

        // Width 8: forced SKP while idle, then the scheduled one at its normal phase.
        do_reset(6'd8);
        for (int n = 1; n <= 1186; n++) begin
            force_skp_i = (n == 10);
            if (n == 11 || n == 1181) push_skp(1);
            tick();
        end
        force_skp_i = 1'b0;

        // Width 32: three expiries saturate at two back-to-back SKP OS.
        do_reset(6'd32);
        stream_then_boundary(900, 4, 2);

        // Simultaneous expiry+force, and expiry on the cycle an insertion starts.
        do_reset(6'd32);
        for (int n = 1; n <= 600; n++) begin
            force_skp_i = (n == 295 || n == 589);
            if (n == 296 || n == 590) begin
                push_skp(4);
                push_skp(4);
            end
            tick();
        end
        force_skp_i = 1'b0;

        // Width 8: reset two beats into an ordered set.
        do_reset(6'd8);
        for (int n = 1; n <= 7; n++) begin
            force_skp_i = (n == 5);
            if (n == 6) push_skp(1);
            tick();
        end
        rst_ni = 1'b0;
        #1;
        chk("async_reset_valid", data_valid_o, 1'b0);
        chk("async_reset_data", data_out_o, 32'h0);
        chk("async_reset_k", data_k_out_o, 4'h0);
        chk("async_reset_skp", skp_sent_o, 1'b0);
        do_reset(6'd8);
        for (int n = 1; n <= 1186; n++) begin
            if (n == 1181) push_skp(1);
            tick();
        end
        chk("final_plan_drained", skp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
